// File: rtl/ld_scalar_mult.sv
// Left-to-right double-and-add sequencer for a combinational Lopez-Dahab point ALU.
// Each cycle issues one ALU op and registers the ALU result into the accumulator.
module ld_scalar_mult #(
    parameter int                   K_W     = 4,
    parameter int                   COORD_W = 4,
    parameter logic [3*COORD_W-1:0] INF_PT  = 12'h006
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [K_W-1:0]         k,
    input  logic [3*COORD_W-1:0]   p_in,
    output logic                   busy,
    output logic                   done,
    output logic [3*COORD_W-1:0]   result,
    output logic                   alu_op,
    output logic [3*COORD_W-1:0]   alu_a,
    output logic [3*COORD_W-1:0]   alu_b,
    input  logic [3*COORD_W-1:0]   alu_r
);

    localparam int PT_W  = 3 * COORD_W;
    localparam int IDX_W = (K_W > 1) ? $clog2(K_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DBL  = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PT_W-1:0]    r_acc;
    logic [PT_W-1:0]    r_p;
    logic [K_W-1:0]     r_k;
    logic [IDX_W-1:0]   r_idx;
    logic [PT_W-1:0]    r_result;
    logic               w_bit;
    logic               w_last;

    assign w_bit  = r_k[r_idx];
    assign w_last = (r_idx == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DONE is entered on the last bit before any decrement, so idx never wraps
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_DBL;
            S_DBL: begin
                if (w_bit)       w_next_state = S_ADD;
                else if (w_last) w_next_state = S_DONE;
                else             w_next_state = S_DBL;
            end
            S_ADD:  w_next_state = w_last ? S_DONE : S_DBL;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        alu_op = 1'b0;
        alu_a  = '0;
        alu_b  = '0;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        case (r_state)
            S_DBL: begin
                alu_op = 1'b1;
                alu_a  = r_acc;
            end
            S_ADD: begin
                alu_op = 1'b0;
                alu_a  = r_p;
                alu_b  = r_acc;
            end
            default: ;
        endcase
    end

    // The result captures the final ALU output on the edge entering DONE
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc    <= INF_PT;
            r_p      <= '0;
            r_k      <= '0;
            r_idx    <= IDX_W'(K_W - 1);
            r_result <= INF_PT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k   <= k;
                        r_p   <= p_in;
                        r_acc <= INF_PT;
                        r_idx <= IDX_W'(K_W - 1);
                    end
                end
                S_DBL: begin
                    r_acc <= alu_r;
                    if (!w_bit) begin
                        if (w_last) r_result <= alu_r;
                        else        r_idx    <= r_idx - 1'b1;
                    end
                end
                S_ADD: begin
                    r_acc <= alu_r;
                    if (w_last) r_result <= alu_r;
                    else        r_idx    <= r_idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_ld_scalar_mult.sv
// Bench for ld_scalar_mult: stand-in point ALU over the multiples of P, a cycle model
// of the double-and-add schedule, and directed scalar vectors with literal expectations.
module tb_ld_scalar_mult;

    localparam int          K_W = 4;
    localparam logic [11:0] P   = 12'h138;
    localparam logic [11:0] INF = 12'h006;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [3:0]  k;
    logic [11:0] p_in;
    logic        busy, done, alu_op;
    logic [11:0] result, alu_a, alu_b, alu_r;

    always #5 clk = ~clk;

    ld_scalar_mult #(.K_W(K_W), .COORD_W(4), .INF_PT(INF)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .k(k), .p_in(p_in),
        .busy(busy), .done(done), .result(result),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
    );

    // Multiples mP: 0..3 are the real curve points, the rest are distinct stand-ins
    function automatic logic [11:0] enc(input int m);
        case (m % 16)
            0: return 12'h006;
            1: return 12'h138;
            2: return 12'hC2E;
            3: return 12'h227;
            default: return 12'hA00 | 12'(m % 16);
        endcase
    endfunction

    function automatic int dec(input logic [11:0] pt);
        for (int m = 0; m < 16; m++) if (enc(m) == pt) return m;
        return -1;
    endfunction

    int da, db;
    always_comb begin
        da    = dec(alu_a);
        db    = dec(alu_b);
        alu_r = 12'hFFF;
        if (alu_op) begin
            if (da >= 0) alu_r = enc(2 * da);
        end else if (da >= 0 && db >= 0) begin
            alu_r = enc(da + db);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected ALU op for step s of scalar kk, walking bits MSB first on multiples of P
    function automatic void sched(input logic [3:0] kk, input int s, output logic op,
                                  output logic [11:0] a, output logic [11:0] b);
        int m = 0;
        int j = 0;
        op = 1'b0; a = '0; b = '0;
        for (int i = K_W - 1; i >= 0; i--) begin
            if (j == s) begin op = 1'b1; a = enc(m); b = '0; return; end
            j++;
            m = 2 * m;
            if (kk[i]) begin
                if (j == s) begin op = 1'b0; a = P; b = enc(m); return; end
                j++;
                m = m + 1;
            end
        end
    endfunction

    int          m_cyc, m_L;
    logic [3:0]  m_k;
    logic [11:0] m_res;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_cyc <= 0;
            m_L   <= 0;
            m_k   <= '0;
            m_res <= INF;
        end else if (m_cyc == 0) begin
            if (start === 1'b1) begin
                m_cyc <= 1;
                m_k   <= k;
                m_L   <= K_W + $countones(k) + 1;
            end
        end else if (m_cyc == m_L) begin
            m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == m_L) m_res <= enc(int'(m_k));
        end
    end

    always @(negedge clk) begin
        logic        eop;
        logic [11:0] ea, eb;
        if (n_rst === 1'b1) begin
            eop = 1'b0; ea = '0; eb = '0;
            if (m_cyc >= 1 && m_cyc < m_L) sched(m_k, m_cyc - 1, eop, ea, eb);
            chk("busy",   32'(busy),   32'(m_cyc != 0));
            chk("done",   32'(done),   32'(m_cyc != 0 && m_cyc == m_L));
            chk("result", 32'(result), 32'(m_res));
            chk("alu_op", 32'(alu_op), 32'(eop));
            chk("alu_a",  32'(alu_a),  32'(ea));
            chk("alu_b",  32'(alu_b),  32'(eb));
        end
    end

    task automatic run_op(input logic [3:0] kk, input bit poke, output int lat,
                          output int adds, output logic [11:0] la,
                          output logic [11:0] lb, output logic [11:0] res);
        @(posedge clk); #2;
        start = 1'b1; k = kk; p_in = P;
        @(posedge clk); #2;
        start = 1'b0; k = '0;
        lat = -1; adds = 0; la = '0; lb = '0; res = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (poke && c == 2) begin start = 1'b1; k = 4'hF; end
            if (poke && c == 3) start = 1'b0;
            if (busy && !done && !alu_op) begin adds++; la = alu_a; lb = alu_b; end
            if (done) begin lat = c; res = result; break; end
        end
    endtask

    int          lat, adds;
    logic [11:0] la, lb, res;

    initial begin
        n_rst = 1'b0; start = 1'b0; k = '0; p_in = '0;
        #12;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'h006);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a",  32'(alu_a),  32'd0);
        chk("rst_alu_b",  32'(alu_b),  32'd0);
        @(negedge clk); #3 n_rst = 1'b1;

        run_op(4'd1, 1'b0, lat, adds, la, lb, res);
        chk("k1_latency", lat, 6);
        chk("k1_result",  32'(res), 32'h138);
        chk("k1_adds",    adds, 1);

        run_op(4'd2, 1'b0, lat, adds, la, lb, res);
        chk("k2_latency", lat, 6);
        chk("k2_result",  32'(res), 32'hC2E);
        chk("k2_adds",    adds, 1);

        run_op(4'd3, 1'b0, lat, adds, la, lb, res);
        chk("k3_latency", lat, 7);
        chk("k3_result",  32'(res), 32'h227);
        chk("k3_last_a",  32'(la), 32'h138);
        chk("k3_last_b",  32'(lb), 32'hC2E);

        run_op(4'd0, 1'b1, lat, adds, la, lb, res);
        chk("k0_latency", lat, 5);
        chk("k0_result",  32'(res), 32'h006);
        chk("k0_adds",    adds, 0);
        repeat (3) @(negedge clk);
        chk("k0_idle_busy",   32'(busy),   32'd0);
        chk("k0_idle_result", 32'(result), 32'h006);

        run_op(4'd15, 1'b0, lat, adds, la, lb, res);
        chk("k15_latency", lat, 9);
        chk("k15_result",  32'(res), 32'hA0F);
        chk("k15_adds",    adds, 4);

        run_op(4'd8, 1'b0, lat, adds, la, lb, res);
        chk("k8_latency", lat, 6);
        chk("k8_result",  32'(res), 32'hA08);

        // Abort mid-operation with an asynchronous reset
        @(posedge clk); #2;
        start = 1'b1; k = 4'd3; p_in = P;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_result", 32'(result), 32'h006);
        chk("abort_alu_op", 32'(alu_op), 32'd0);
        chk("abort_alu_a",  32'(alu_a),  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        #3 n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle_result", 32'(result), 32'h006);

        run_op(4'd3, 1'b0, lat, adds, la, lb, res);
        chk("rerun_latency", lat, 7);
        chk("rerun_result",  32'(res), 32'h227);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
